// File: rtl/adc_fp_capture.sv
// Signed ADC code capture: optional box-car averaging, scaling to Q(INT).(FP-INT) volts,
// calibration gain/offset with saturation, and a one-entry valid/ready output register.
module adc_fp_capture #(
    parameter int unsigned         FP_WIDTH  = 64,
    parameter int unsigned         INT_WIDTH = 16,
    parameter int unsigned         ADC_WIDTH = 14,
    parameter int unsigned         AVG_LOG2  = 0,
    parameter logic [FP_WIDTH-1:0] LSB_SCALE = 64'h0000_0050_0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADC_WIDTH-1:0] adc_code,
    input  logic                 adc_valid,
    input  logic [FP_WIDTH-1:0]  ADC_CAL_GAIN,
    input  logic [FP_WIDTH-1:0]  ADC_CAL_OFFSET,
    output logic [FP_WIDTH-1:0]  fp_out,
    output logic                 fp_valid,
    input  logic                 fp_ready,
    output logic                 sat,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int unsigned FRAC_W = FP_WIDTH - INT_WIDTH;
    localparam int unsigned ACC_W  = ADC_WIDTH + AVG_LOG2;
    localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned PROD_W = 2 * FP_WIDTH;
    localparam int unsigned TOP_W  = FP_WIDTH + INT_WIDTH;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [FP_WIDTH-1:0] POS_MAX  = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam logic [FP_WIDTH-1:0] NEG_MAX  = {1'b1, {(FP_WIDTH-1){1'b0}}};

    // S1: window accumulator
    logic signed [ACC_W-1:0]     acc;
    logic        [CNT_W-1:0]     cnt;
    logic signed [ACC_W-1:0]     code_ext;
    logic signed [ACC_W-1:0]     win_sum;
    logic signed [ADC_WIDTH-1:0] mean_next;
    logic signed [ADC_WIDTH-1:0] s1_mean;
    logic signed [FP_WIDTH-1:0]  s1_gain;
    logic        [FP_WIDTH-1:0]  s1_off;
    logic                        s1_valid;

    assign code_ext  = ACC_W'($signed(adc_code));
    assign win_sum   = acc + code_ext;
    assign mean_next = ADC_WIDTH'(win_sum >>> AVG_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            s1_mean  <= '0;
            s1_gain  <= '0;
            s1_off   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            if (adc_valid) begin
                if (cnt == CNT_LAST) begin
                    s1_mean  <= mean_next;
                    s1_gain  <= ADC_CAL_GAIN;
                    s1_off   <= ADC_CAL_OFFSET;
                    s1_valid <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= win_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // S2: code -> volts; the mean is an integer so the product stays in Q format
    logic signed [FP_WIDTH-1:0] mean_fp;
    logic signed [FP_WIDTH-1:0] v_next;
    logic signed [FP_WIDTH-1:0] s2_v;
    logic signed [FP_WIDTH-1:0] s2_gain;
    logic        [FP_WIDTH-1:0] s2_off;
    logic                       s2_valid;

    assign mean_fp = FP_WIDTH'(s1_mean);
    assign v_next  = mean_fp * $signed(LSB_SCALE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v     <= '0;
            s2_gain  <= '0;
            s2_off   <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_v    <= v_next;
                s2_gain <= s1_gain;
                s2_off  <= s1_off;
            end
        end
    end

    // S3: gain multiply; top holds the product realigned to Q format plus the
    // discarded integer bits, which must all equal the kept sign bit
    logic signed [PROD_W-1:0]   prod;
    logic signed [TOP_W-1:0]    top;
    logic                       g_ovf;
    logic signed [FP_WIDTH-1:0] s3_g;
    logic        [FP_WIDTH-1:0] s3_off;
    logic                       s3_ovf;
    logic                       s3_neg;
    logic                       s3_valid;

    assign prod  = PROD_W'(s2_v) * PROD_W'(s2_gain);
    assign top   = TOP_W'(prod >>> FRAC_W);
    assign g_ovf = !((&top[TOP_W-1:FP_WIDTH-1]) || !(|top[TOP_W-1:FP_WIDTH-1]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_g     <= '0;
            s3_off   <= '0;
            s3_ovf   <= 1'b0;
            s3_neg   <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_g   <= top[FP_WIDTH-1:0];
                s3_off <= s2_off;
                s3_ovf <= g_ovf;
                s3_neg <= top[TOP_W-1];
            end
        end
    end

    // S4: offset add with one guard bit, then saturate
    logic [FP_WIDTH:0]   r_sum;
    logic                sum_ovf;
    logic [FP_WIDTH-1:0] r_next;
    logic                sat_next;
    logic [FP_WIDTH-1:0] s4_out;
    logic                s4_sat;
    logic                s4_valid;

    assign r_sum   = {s3_g[FP_WIDTH-1], s3_g} + {s3_off[FP_WIDTH-1], s3_off};
    assign sum_ovf = r_sum[FP_WIDTH] ^ r_sum[FP_WIDTH-1];

    always_comb begin
        r_next   = r_sum[FP_WIDTH-1:0];
        sat_next = 1'b0;
        if (s3_ovf) begin
            r_next   = s3_neg ? NEG_MAX : POS_MAX;
            sat_next = 1'b1;
        end else if (sum_ovf) begin
            r_next   = r_sum[FP_WIDTH] ? NEG_MAX : POS_MAX;
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s4_out   <= '0;
            s4_sat   <= 1'b0;
            s4_valid <= 1'b0;
        end else begin
            s4_valid <= s3_valid;
            if (s3_valid) begin
                s4_out <= r_next;
                s4_sat <= sat_next;
            end
        end
    end

    // Output register: a new result always loads; it only counts as an overrun
    // when the held one is neither consumed nor already empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fp_out   <= '0;
            sat      <= 1'b0;
            fp_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (s4_valid) begin
                fp_out   <= s4_out;
                sat      <= s4_sat;
                fp_valid <= 1'b1;
            end else if (fp_valid && fp_ready) begin
                fp_valid <= 1'b0;
            end
            if (s4_valid && fp_valid && !fp_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
